// File: rtl/lif_post_neuron_if.sv
// Bundle of neuron control, synapse-write and observation signals.
// Latency: none, wiring only.
// Backpressure: none; the master stalls the neuron through en.
interface lif_post_neuron_if #(
  parameter int NUM_PRE = 5,
  parameter int W_WIDTH = 8,
  parameter int V_WIDTH = 12
);
  logic               en;
  logic [NUM_PRE-1:0] pre_spike;
  logic               w_wr_en;
  logic [2:0]         w_wr_addr;
  logic [W_WIDTH-1:0] w_wr_data;
  logic [V_WIDTH-1:0] thresh;
  logic               post_spike;
  logic [V_WIDTH-1:0] v_mem;
  logic               refractory;
  logic [7:0]         spike_count;

  modport master (
    output en, pre_spike, w_wr_en, w_wr_addr, w_wr_data, thresh,
    input  post_spike, v_mem, refractory, spike_count
  );

  modport slave (
    input  en, pre_spike, w_wr_en, w_wr_addr, w_wr_data, thresh,
    output post_spike, v_mem, refractory, spike_count
  );
endinterface

// File: rtl/lif_post_neuron.sv
// Leaky integrate-and-fire neuron; optional adaptive threshold under LIF_ADAPT_THRESH_EN.
// Latency: pre_spike sampled at edge N is reflected in v_mem/post_spike right after edge N.
// Backpressure: none; en=0 freezes neuron state and squashes post_spike, weight writes still land.
module lif_post_neuron #(
  parameter int NUM_PRE       = 5,
  parameter int W_WIDTH       = 8,
  parameter int V_WIDTH       = 12,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRAC_CYCLES = 4
) (
  input logic              clk,
  input logic              rst_n,
  lif_post_neuron_if.slave bus
);

  localparam int SUM_W = V_WIDTH + 3;
  localparam int TH_W  = V_WIDTH + 1;
  localparam int CNT_W = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;

  localparam logic [0:0] ST_INTEGRATE = 1'b0;
  localparam logic [0:0] ST_REFRAC    = 1'b1;

  localparam logic [V_WIDTH-1:0] V_MAX       = '1;
  localparam logic [CNT_W-1:0]   REFRAC_LOAD = CNT_W'(REFRAC_CYCLES);

  logic [W_WIDTH-1:0] weight [NUM_PRE];
  logic [0:0]         state;
  logic [CNT_W-1:0]   rcnt;
  logic [V_WIDTH-1:0] v_q;
  logic               post_q;
  logic               refr_q;
  logic [7:0]         cnt_q;

  logic [SUM_W-1:0]   syn_sum;
  logic [SUM_W-1:0]   v_sum;
  logic [V_WIDTH-1:0] v_leak;
  logic [V_WIDTH-1:0] v_next;
  logic [TH_W-1:0]    thresh_eff;
  logic               fire;

  // Sum the weights of every input spiking this cycle (pre-write weights).
  always_comb begin
    syn_sum = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      if (bus.pre_spike[i]) syn_sum = syn_sum + SUM_W'(weight[i]);
    end
  end

  // Shift leak, add synaptic input, clamp to the top of the potential range.
  always_comb begin
    v_leak = v_q - (v_q >> LEAK_SHIFT);
    v_sum  = SUM_W'(v_leak) + syn_sum;
    v_next = (v_sum > SUM_W'(V_MAX)) ? V_MAX : v_sum[V_WIDTH-1:0];
  end

`ifdef LIF_ADAPT_THRESH_EN
  logic [7:0] offset_q;

  assign thresh_eff = {1'b0, bus.thresh} + TH_W'(offset_q);

  // Fires raise the threshold by 16 (capped at 255); quiet enabled edges relax it by 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      offset_q <= 8'd0;
    end else if (bus.en) begin
      if (fire) offset_q <= (offset_q > 8'd239) ? 8'd255 : offset_q + 8'd16;
      else if (offset_q != 8'd0) offset_q <= offset_q - 8'd1;
    end
  end
`else
  assign thresh_eff = {1'b0, bus.thresh};
`endif

  // A fire can only happen while integrating; the compare is one bit wider than v.
  assign fire = (state == ST_INTEGRATE) && ({1'b0, v_next} >= thresh_eff);

  // Synapse weight table: writes ignore en and out-of-range addresses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PRE; i++) weight[i] <= '0;
    end else if (bus.w_wr_en && (int'(bus.w_wr_addr) < NUM_PRE)) begin
      weight[bus.w_wr_addr] <= bus.w_wr_data;
    end
  end

  // Integrate/fire/refractory state machine; en=0 holds everything but the fire pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_INTEGRATE;
      rcnt   <= '0;
      v_q    <= '0;
      post_q <= 1'b0;
      refr_q <= 1'b0;
      cnt_q  <= 8'd0;
    end else if (!bus.en) begin
      post_q <= 1'b0;
    end else if (state == ST_INTEGRATE) begin
      if (fire) begin
        post_q <= 1'b1;
        v_q    <= '0;
        cnt_q  <= cnt_q + 8'd1;
        if (REFRAC_CYCLES > 0) begin
          state  <= ST_REFRAC;
          rcnt   <= REFRAC_LOAD;
          refr_q <= 1'b1;
        end
      end else begin
        post_q <= 1'b0;
        v_q    <= v_next;
      end
    end else begin
      post_q <= 1'b0;
      v_q    <= '0;
      rcnt   <= rcnt - CNT_W'(1);
      if (rcnt <= CNT_W'(1)) begin
        state  <= ST_INTEGRATE;
        refr_q <= 1'b0;
      end
    end
  end

  assign bus.post_spike  = post_q;
  assign bus.v_mem       = v_q;
  assign bus.refractory  = refr_q;
  assign bus.spike_count = cnt_q;

endmodule
